// File: rtl/axis_serdes_pkg.sv
// Shared types and helpers for the AXI-Stream width converter.
package axis_serdes_pkg;

    typedef enum logic {
        SERIALIZE   = 1'b0,
        DESERIALIZE = 1'b1
    } conv_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int lane_ratio(input int dw, input int lw);
        return dw / lw;
    endfunction

endpackage

// File: rtl/axis_lane_ctr.sv
// Wrapping lane counter (0..RATIO-1) with synchronous clear, count enable and last-lane flag.
module axis_lane_ctr #(
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = (count == CW'(RATIO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/axis_width_conv.sv
// AXI-Stream width converter: word->lanes (MODE=0) or lanes->word (MODE=1), single clock.
// Optional packet tracking (tlast/tkeep) is enabled by defining AXIS_WCONV_TLAST_EN.
module axis_width_conv
    import axis_serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter int MODE       = 0,
    parameter int LSB_FIRST  = 1
) (
    input  logic                                              axis_aclk,
    input  logic                                              axis_reset,
    input  logic [(MODE == 0 ? DATA_WIDTH : LANE_WIDTH)-1:0]  s_axis_tdata,
    input  logic                                              s_axis_tvalid,
    output logic                                              s_axis_tready,
`ifdef AXIS_WCONV_TLAST_EN
    input  logic                                              s_axis_tlast,
    output logic                                              m_axis_tlast,
    output logic [DATA_WIDTH/LANE_WIDTH-1:0]                  m_axis_tkeep,
`endif
    output logic [(MODE == 0 ? LANE_WIDTH : DATA_WIDTH)-1:0]  m_axis_tdata,
    output logic                                              m_axis_tvalid,
    input  logic                                              m_axis_tready,
    output logic                                              busy
);

    localparam int R  = lane_ratio(DATA_WIDTH, LANE_WIDTH);
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    if ((DATA_WIDTH % LANE_WIDTH) != 0 || R < 2) begin : g_param_check
        $error("axis_width_conv: DATA_WIDTH must be a multiple (>=2) of LANE_WIDTH");
    end

    logic [CW-1:0] lane_cnt;
    logic          lane_last;
    logic          ctr_en;
    logic          ctr_clear;
    logic          s_fire;
    logic          m_fire;

    assign s_fire = s_axis_tvalid && s_axis_tready;
    assign m_fire = m_axis_tvalid && m_axis_tready;
    assign busy   = (lane_cnt != '0);

    axis_lane_ctr #(.RATIO(R), .CW(CW)) u_lane_ctr (
        .clk   (axis_aclk),
        .rst   (axis_reset),
        .clear (ctr_clear),
        .en    (ctr_en),
        .count (lane_cnt),
        .last  (lane_last)
    );

    if (MODE == int'(SERIALIZE)) begin : g_ser
        ser_state_e            state;
        ser_state_e            state_next;
        logic [DATA_WIDTH-1:0] shreg;

        function automatic logic [LANE_WIDTH-1:0] head_lane(input logic [DATA_WIDTH-1:0] w);
            return (LSB_FIRST != 0) ? w[LANE_WIDTH-1:0] : w[DATA_WIDTH-1 -: LANE_WIDTH];
        endfunction

        function automatic logic [DATA_WIDTH-1:0] drop_lane(input logic [DATA_WIDTH-1:0] w);
            return (LSB_FIRST != 0) ? (w >> LANE_WIDTH) : (w << LANE_WIDTH);
        endfunction

        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) state <= IDLE;
            else            state <= state_next;
        end

        // A new word may only arrive together with the last lane, so SHIFT continues seamlessly.
        always_comb begin
            state_next = state;
            case (state)
                IDLE:    if (s_fire) state_next = SHIFT;
                SHIFT:   if (m_fire && lane_last && !s_fire) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        always_comb begin
            s_axis_tready = 1'b0;
            if (!axis_reset) begin
                case (state)
                    IDLE:    s_axis_tready = 1'b1;
                    SHIFT:   s_axis_tready = lane_last && m_axis_tready;
                    default: s_axis_tready = 1'b0;
                endcase
            end
        end

        assign ctr_en    = (state == SHIFT) && m_fire;
        assign ctr_clear = 1'b0;

        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                shreg         <= '0;
            end else if (s_fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= head_lane(s_axis_tdata);
                shreg         <= drop_lane(s_axis_tdata);
            end else if (m_fire) begin
                if (lane_last) begin
                    m_axis_tvalid <= 1'b0;
                end else begin
                    m_axis_tdata <= head_lane(shreg);
                    shreg        <= drop_lane(shreg);
                end
            end
        end

`ifdef AXIS_WCONV_TLAST_EN
        logic word_last;

        // tlast rides on the lane that is about to become lane R-1.
        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) begin
                word_last    <= 1'b0;
                m_axis_tlast <= 1'b0;
            end else if (s_fire) begin
                word_last    <= s_axis_tlast;
                m_axis_tlast <= 1'b0;
            end else if (m_fire) begin
                m_axis_tlast <= !lane_last && word_last && (lane_cnt == CW'(R - 2));
            end
        end

        assign m_axis_tkeep = '0;
`endif
    end else begin : g_des
        logic [DATA_WIDTH-1:0] acc;
        logic [DATA_WIDTH-1:0] acc_next;
        logic                  flush;

        assign s_axis_tready = !axis_reset && (!m_axis_tvalid || m_axis_tready);
        assign ctr_en        = s_fire;

`ifdef AXIS_WCONV_TLAST_EN
        assign flush     = s_fire && (lane_last || s_axis_tlast);
        assign ctr_clear = s_fire && s_axis_tlast;
`else
        assign flush     = s_fire && lane_last;
        assign ctr_clear = 1'b0;
`endif

        always_comb begin
            acc_next = acc;
            for (int i = 0; i < R; i++) begin
                if (lane_cnt == CW'(i)) begin
                    acc_next[((LSB_FIRST != 0) ? i : R - 1 - i) * LANE_WIDTH +: LANE_WIDTH] = s_axis_tdata;
                end
            end
        end

        // The accumulator is cleared on every flush so short packets come out zero-padded.
        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                acc           <= '0;
            end else if (flush) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= acc_next;
                acc           <= '0;
            end else begin
                if (s_fire) acc <= acc_next;
                if (m_fire) m_axis_tvalid <= 1'b0;
            end
        end

`ifdef AXIS_WCONV_TLAST_EN
        logic [R-1:0] keep_next;

        always_comb begin
            keep_next = '0;
            for (int i = 0; i < R; i++) begin
                keep_next[i] = (CW'(i) <= lane_cnt);
            end
        end

        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) begin
                m_axis_tlast <= 1'b0;
                m_axis_tkeep <= '0;
            end else if (flush) begin
                m_axis_tlast <= s_axis_tlast;
                m_axis_tkeep <= keep_next;
            end
        end
`endif
    end

endmodule
